// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite attribute scanner: attribute byte
// layout, per-entry byte offsets and the scanner state encoding.
package sprite_pkg;

    localparam int ATTR_HIDE     = 7;
    localparam int ATTR_SIZE32   = 6;
    localparam int ATTR_FLIPX    = 5;
    localparam int ATTR_X8       = 4;
    localparam int ATTR_COLOR_HI = 3;
    localparam int ATTR_COLOR_LO = 0;

    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_X    = 2'd1;
    localparam logic [1:0] OFS_TILE = 2'd2;
    localparam logic [1:0] OFS_ATTR = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_RD4,
        S_EVAL,
        S_EMIT,
        S_NEXT,
        S_DONE
    } scan_state_e;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational vertical hit test for one sprite entry against a scanline.
// The row difference wraps mod 256 so sprites straddling line 0 still hit.
module sprite_hit_test
    import sprite_pkg::*;
(
    input  logic [7:0] line,
    input  logic [7:0] y,
    input  logic       attr_hide,
    input  logic       attr_size32,
    output logic       hit,
    output logic [4:0] row
);

    logic [7:0] diff;

    always_comb begin
        diff = line - y;
        hit  = !attr_hide && (diff < (attr_size32 ? 8'd32 : 8'd16));
        row  = diff[4:0];
    end

endmodule

// File: rtl/sprite_attr_scanner.sv
// Per-scanline sprite attribute RAM scanner feeding the line-buffer renderer.
// Define SPRITE_SCAN_OVERFLOW_EN to enforce the MAX_PER_LINE hit limit.
module sprite_attr_scanner
    import sprite_pkg::*;
#(
    parameter int                NUM_SPRITES  = 64,
    parameter int                ADDR_W       = 13,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 13'h1800,
    parameter int                MAX_PER_LINE = 16
) (
    input  logic              CLK_6M,
    input  logic              rst,
    input  logic              line_start,
    input  logic [7:0]        line,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_x,
    output logic [7:0]        out_tile,
    output logic [4:0]        out_row,
    output logic              out_flipx,
    output logic [3:0]        out_color,
    output logic              scan_done,
    output logic              overflow
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_SPRITES - 1);

    scan_state_e       state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [7:0]        line_q, line_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        tile_q, tile_d;
    logic [7:0]        attr_q, attr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        ox_q, ox_d;
    logic [7:0]        otile_q, otile_d;
    logic [4:0]        orow_q, orow_d;
    logic              oflip_q, oflip_d;
    logic [3:0]        ocol_q, ocol_d;
    logic              hit;
    logic [4:0]        row;

`ifdef SPRITE_SCAN_OVERFLOW_EN
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
`endif

    sprite_hit_test u_hit (
        .line       (line_q),
        .y          (y_q),
        .attr_hide  (attr_q[ATTR_HIDE]),
        .attr_size32(attr_q[ATTR_SIZE32]),
        .hit        (hit),
        .row        (row)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        line_d  = line_q;
        y_d     = y_q;
        x_d     = x_q;
        tile_d  = tile_q;
        attr_d  = attr_q;
        addr_d  = addr_q;
        ox_d    = ox_q;
        otile_d = otile_q;
        orow_d  = orow_q;
        oflip_d = oflip_q;
        ocol_d  = ocol_q;
`ifdef SPRITE_SCAN_OVERFLOW_EN
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: ;
            S_RD0:  state_d = S_RD1;
            S_RD1: begin
                y_d     = ram_data;
                state_d = S_RD2;
            end
            S_RD2: begin
                x_d     = ram_data;
                state_d = S_RD3;
            end
            S_RD3: begin
                tile_d  = ram_data;
                state_d = S_RD4;
            end
            S_RD4: begin
                attr_d  = ram_data;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (hit) begin
                    ox_d    = {attr_q[ATTR_X8], x_q};
                    otile_d = tile_q;
                    orow_d  = row;
                    oflip_d = attr_q[ATTR_FLIPX];
                    ocol_d  = attr_q[ATTR_COLOR_HI:ATTR_COLOR_LO];
                    state_d = S_EMIT;
`ifdef SPRITE_SCAN_OVERFLOW_EN
                    // The first hit past the limit is swallowed and ends the line.
                    if (cnt_q == CNT_W'(MAX_PER_LINE)) begin
                        ovf_d   = 1'b1;
                        ox_d    = ox_q;
                        otile_d = otile_q;
                        orow_d  = orow_q;
                        oflip_d = oflip_q;
                        ocol_d  = ocol_q;
                        state_d = S_DONE;
                    end
`endif
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
`ifdef SPRITE_SCAN_OVERFLOW_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RD0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A new line always wins, including an abort of a scan in flight.
        if (line_start) begin
            state_d = S_RD0;
            line_d  = line;
            idx_d   = 6'd0;
`ifdef SPRITE_SCAN_OVERFLOW_EN
            cnt_d   = '0;
            ovf_d   = 1'b0;
`endif
        end

        unique case (state_d)
            S_RD0:   addr_d = BASE_ADDR | ADDR_W'({idx_d, OFS_Y});
            S_RD1:   addr_d = BASE_ADDR | ADDR_W'({idx_d, OFS_X});
            S_RD2:   addr_d = BASE_ADDR | ADDR_W'({idx_d, OFS_TILE});
            S_RD3:   addr_d = BASE_ADDR | ADDR_W'({idx_d, OFS_ATTR});
            default: ;
        endcase
    end

    always_ff @(posedge CLK_6M or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            y_q     <= '0;
            x_q     <= '0;
            tile_q  <= '0;
            attr_q  <= '0;
            addr_q  <= '0;
            ox_q    <= '0;
            otile_q <= '0;
            orow_q  <= '0;
            oflip_q <= 1'b0;
            ocol_q  <= '0;
`ifdef SPRITE_SCAN_OVERFLOW_EN
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            y_q     <= y_d;
            x_q     <= x_d;
            tile_q  <= tile_d;
            attr_q  <= attr_d;
            addr_q  <= addr_d;
            ox_q    <= ox_d;
            otile_q <= otile_d;
            orow_q  <= orow_d;
            oflip_q <= oflip_d;
            ocol_q  <= ocol_d;
`ifdef SPRITE_SCAN_OVERFLOW_EN
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    logic rd_active;
    assign rd_active = state_q inside {S_RD0, S_RD1, S_RD2, S_RD3};

    assign ram_ce_n  = !rd_active;
    assign ram_oe_n  = !rd_active;
    assign ram_addr  = addr_q;
    assign out_valid = (state_q == S_EMIT) && !line_start;
    assign out_x     = ox_q;
    assign out_tile  = otile_q;
    assign out_row   = orow_q;
    assign out_flipx = oflip_q;
    assign out_color = ocol_q;
    assign scan_done = (state_q == S_DONE);
`ifdef SPRITE_SCAN_OVERFLOW_EN
    assign overflow  = ovf_q;
`else
    assign overflow  = 1'b0;
`endif

endmodule
